alu_muldiv_cu: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. Decodes RV32I ALU function codes for the base datapath and adds a sequential RV32M multiply/divide engine with a stall/done handshake. Sits in the execute stage beside the main ALU: the `alufn` path stays combinational, while M-extension instructions are captured, iterated over `XLEN` cycles and returned on `md_result`.

---
 rtl/alu_muldiv_cu.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_muldiv_cu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_cu.sv
// alu_muldiv_cu: RV32I ALU control decoder plus a sequential RV32M
// multiply/divide engine with a stall/done handshake.
//
// The alufn/is_mext path is purely combinational. M-extension ops are
// captured in IDLE, iterated one bit per cycle in CALC (shift-add multiply or
// restoring divide on operand magnitudes), sign-corrected in FIX and returned
// on o_md_result with a one-cycle o_md_done pulse in DONE.
//
// Optional feature macro: ALU_FAST_MUL_EN
//   defined   - MUL/MULH/MULHSU/MULHU form the full product at accept and go
//               straight to FIX (done at cycle 2); division stays iterative.
//   undefined - every M op uses the iterative path (done at cycle XLEN+2).
//
// Handshake: an op is accepted on the rising edge that ends a cycle in which
// the FSM is IDLE and i_in_valid & o_is_mext & !i_kill all hold. o_stall is
// high from that cycle until the cycle before DONE; o_md_done is high only in
// DONE, where o_md_result is valid and o_stall is low so the pipeline retires
// the instruction. i_in_valid is ignored outside IDLE. i_kill returns the FSM
// to IDLE at the next edge without touching o_md_result.

module alu_muldiv_cu #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [31:0]     i_instruction,
  input  logic [1:0]      i_alu_op,
  input  logic            i_in_valid,
  input  logic            i_kill,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  output logic [3:0]      o_alufn,
  output logic            o_is_mext,
  output logic            o_stall,
  output logic            o_md_done,
  output logic [XLEN-1:0] o_md_result,
  output logic [1:0]      o_dbg_state
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b;
  logic [2:0]          r_f3;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_special;
  logic [XLEN-1:0]     r_special_val;
  logic [XLEN-1:0]     r_md_result;

  // Instruction fields this block does not look at.
  logic w_unused;
  assign w_unused = ^{i_instruction[24:15], i_instruction[11:6], i_instruction[4:0]};

  logic [2:0] w_funct3;
  logic       w_is_mext;
  assign w_funct3  = i_instruction[14:12];
  assign w_is_mext = (i_alu_op == 2'b11) & i_instruction[5] &
                     (i_instruction[31:25] == 7'b0000001);

  // ALU function decode; M ops force the NOP code so the main ALU idles.
  always_comb begin
    o_alufn = 4'b0011;
    case (i_alu_op)
      2'b00: o_alufn = 4'b0011;
      2'b01: o_alufn = 4'b0001;
      2'b10: o_alufn = 4'b0000;
      default: begin
        case (w_funct3)
          3'b000:  o_alufn = (i_instruction[5] & i_instruction[30]) ? 4'b0001 : 4'b0000;
          3'b001:  o_alufn = 4'b1000;
          3'b010:  o_alufn = 4'b1101;
          3'b011:  o_alufn = 4'b1111;
          3'b100:  o_alufn = 4'b0111;
          3'b101:  o_alufn = i_instruction[30] ? 4'b1010 : 4'b1001;
          3'b110:  o_alufn = 4'b0100;
          default: o_alufn = 4'b0101;
        endcase
      end
    endcase
    if (w_is_mext) o_alufn = 4'b0011;
  end

  // Operand classification at accept. funct3[2] selects divide; for divides
  // funct3[0] marks the unsigned variants, for multiplies MULHSU/MULHU treat
  // rs2 as unsigned and only MULHU treats rs1 as unsigned.
  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_val;
  logic            w_fast_mul;

  assign w_accept   = (r_state == S_IDLE) & i_in_valid & w_is_mext & ~i_kill;
  assign w_is_div   = w_funct3[2];
  assign w_a_signed = w_is_div ? ~w_funct3[0] : (w_funct3 != 3'b011);
  assign w_b_signed = w_is_div ? ~w_funct3[0] : ~w_funct3[1];
  assign w_a_neg    = w_a_signed & i_rs1_val[XLEN-1];
  assign w_b_neg    = w_b_signed & i_rs2_val[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~i_rs1_val + 1'b1) : i_rs1_val;
  assign w_b_mag    = w_b_neg ? (~i_rs2_val + 1'b1) : i_rs2_val;
  assign w_div_zero = w_is_div & (i_rs2_val == '0);
  assign w_div_ovf  = w_is_div & ~w_funct3[0] & (i_rs1_val == MIN_NEG) &
                      (i_rs2_val == {XLEN{1'b1}});
  assign w_special  = w_div_zero | w_div_ovf;

  // Fixed results for divide-by-zero and signed overflow (funct3[1] = REM).
  always_comb begin
    w_special_val = '0;
    if (w_div_zero)
      w_special_val = w_funct3[1] ? i_rs1_val : {XLEN{1'b1}};
    else if (w_div_ovf)
      w_special_val = w_funct3[1] ? '0 : i_rs1_val;
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_mul  = ~w_is_div;
  assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
`else
  assign w_fast_mul  = 1'b0;
`endif

  // One iteration step. Multiply: {hi, lo} with lo holding the multiplier;
  // add the multiplicand into hi when lo[0] is set, then shift right.
  // Divide: {rem, quot} shifted left one bit; subtract the divisor from the
  // partial remainder and keep it only when it does not go negative.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_rs;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_rs   = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff = w_div_rs - {1'b0, r_b};
  assign w_div_next = w_div_diff[XLEN] ?
                      {w_div_rs[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0} :
                      {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // Sign correction and word selection used in FIX.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot_mag;
  logic [XLEN-1:0]   w_rem_mag;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  assign w_prod     = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot_mag = r_acc[XLEN-1:0];
  assign w_rem_mag  = r_acc[2*XLEN-1:XLEN];
  assign w_quot     = r_neg_q ? (~w_quot_mag + 1'b1) : w_quot_mag;
  assign w_rem      = r_neg_r ? (~w_rem_mag + 1'b1) : w_rem_mag;

  // Final result mux: special value, multiply low/high word, REM or DIV.
  always_comb begin
    w_result = '0;
    if (r_special)
      w_result = r_special_val;
    else if (!r_f3[2])
      w_result = (r_f3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (r_f3[1])
      w_result = w_rem;
    else
      w_result = w_quot;
  end

  // Control FSM with its datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_b           <= '0;
      r_f3          <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_md_result   <= '0;
    end else if (i_kill) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3          <= w_funct3;
            r_neg_q       <= w_a_neg ^ w_b_neg;
            r_neg_r       <= w_a_neg;
            r_cnt         <= '0;
            r_special     <= w_special;
            r_special_val <= w_special_val;
            if (w_is_div) begin
              r_acc <= {{XLEN{1'b0}}, w_a_mag};
              r_b   <= w_b_mag;
            end else begin
              r_acc <= {{XLEN{1'b0}}, w_b_mag};
              r_b   <= w_a_mag;
            end
`ifdef ALU_FAST_MUL_EN
            if (w_fast_mul) r_acc <= w_fast_prod;
`endif
            r_state <= (w_special | w_fast_mul) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_f3[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_md_result <= w_result;
          r_state     <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_is_mext   = w_is_mext;
  assign o_stall     = w_accept | (r_state == S_CALC) | (r_state == S_FIX);
  assign o_md_done   = (r_state == S_DONE);
  assign o_md_result = r_md_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_muldiv_cu.sv
// Bench for alu_muldiv_cu: decode vector table, M-op vector table with
// hand-computed results and completion cycles, plus kill/reset sequences.

module tb_alu_muldiv_cu;

  localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = XLEN + 2;
`endif
  localparam int DIV_CYC = XLEN + 2;

  // Clock / reset / DUT
  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instruction;
  logic [1:0]      alu_op;
  logic            in_valid;
  logic            kill;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [3:0]      alufn;
  logic            is_mext;
  logic            stall;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  alu_muldiv_cu #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_instruction(instruction), .i_alu_op(alu_op),
    .i_in_valid(in_valid), .i_kill(kill), .i_rs1_val(rs1_val), .i_rs2_val(rs2_val),
    .o_alufn(alufn), .o_is_mext(is_mext), .o_stall(stall), .o_md_done(md_done),
    .o_md_result(md_result), .o_dbg_state(dbg_state)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] instr;
    logic [3:0] alufn;
    logic       mext;
  } dec_vec_t;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          cyc;
  } md_vec_t;

  // Driver: issue one M op at a negedge and follow it to md_done.
  task automatic run_m(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
    int cyc;
    bit stall_ok;
    @(negedge clk);
    alu_op      = 2'b11;
    instruction = mk(7'b0000001, f3, 7'b0110011);
    rs1_val     = a;
    rs2_val     = b;
    in_valid    = 1'b1;
    exp_q.push_back(exp);
    #1;
    check({name, " stall_c0"}, 64'(stall), 64'd1);
    stall_ok = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rs1_val  = $urandom;
    rs2_val  = $urandom;
    cyc = 1;
    while (!md_done && cyc < 100) begin
      if (!stall) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({name, " result"}, 64'(md_result), 64'(exp_q.pop_front()));
    check({name, " stall_held"}, 64'(stall_ok), 64'd1);
    check({name, " stall_in_done"}, 64'(stall), 64'd0);
    @(negedge clk);
    check({name, " done_pulse"}, 64'(md_done), 64'd0);
  endtask

  dec_vec_t dec_tab[14];
  md_vec_t  md_tab[13];

  initial begin
    logic [XLEN-1:0] held;
    bit seen_done;

    dec_tab[0]  = '{"addi_b30", 2'b11, mk(7'b0100000, 3'b000, 7'b0010011), 4'b0000, 1'b0};
    dec_tab[1]  = '{"sub",      2'b11, mk(7'b0100000, 3'b000, 7'b0110011), 4'b0001, 1'b0};
    dec_tab[2]  = '{"srai",     2'b11, mk(7'b0100000, 3'b101, 7'b0010011), 4'b1010, 1'b0};
    dec_tab[3]  = '{"srli",     2'b11, mk(7'b0000000, 3'b101, 7'b0010011), 4'b1001, 1'b0};
    dec_tab[4]  = '{"mul",      2'b11, mk(7'b0000001, 3'b000, 7'b0110011), 4'b0011, 1'b1};
    dec_tab[5]  = '{"slt",      2'b11, mk(7'b0000000, 3'b010, 7'b0110011), 4'b1101, 1'b0};
    dec_tab[6]  = '{"sltu",     2'b11, mk(7'b0000000, 3'b011, 7'b0110011), 4'b1111, 1'b0};
    dec_tab[7]  = '{"xor",      2'b11, mk(7'b0000000, 3'b100, 7'b0110011), 4'b0111, 1'b0};
    dec_tab[8]  = '{"or",       2'b11, mk(7'b0000000, 3'b110, 7'b0110011), 4'b0100, 1'b0};
    dec_tab[9]  = '{"and",      2'b11, mk(7'b0000000, 3'b111, 7'b0110011), 4'b0101, 1'b0};
    dec_tab[10] = '{"sll",      2'b11, mk(7'b0000000, 3'b001, 7'b0110011), 4'b1000, 1'b0};
    dec_tab[11] = '{"op00_m",   2'b00, mk(7'b0000001, 3'b100, 7'b0110011), 4'b0011, 1'b0};
    dec_tab[12] = '{"op01",     2'b01, mk(7'b0000000, 3'b000, 7'b0010011), 4'b0001, 1'b0};
    dec_tab[13] = '{"m_f7_imm", 2'b11, mk(7'b0000001, 3'b000, 7'b0010011), 4'b0000, 1'b0};

    md_tab[0]  = '{"mul_7x-3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_CYC};
    md_tab[1]  = '{"mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_CYC};
    md_tab[2]  = '{"mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_CYC};
    md_tab[3]  = '{"mulhsu_-1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_CYC};
    md_tab[4]  = '{"div_-7/2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_CYC};
    md_tab[5]  = '{"rem_-7/2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_CYC};
    md_tab[6]  = '{"divu_100/0",  3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 2};
    md_tab[7]  = '{"remu_100/0",  3'b111, 32'd100,      32'd0,        32'd100,      2};
    md_tab[8]  = '{"div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    md_tab[9]  = '{"rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    md_tab[10] = '{"divu_100/7",  3'b101, 32'd100,      32'd7,        32'd14,       DIV_CYC};
    md_tab[11] = '{"remu_100/7",  3'b111, 32'd100,      32'd7,        32'd2,        DIV_CYC};
    md_tab[12] = '{"div_7/-2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_CYC};

    // Reset
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; alu_op = 2'b00;
    instruction = 32'h0; rs1_val = '0; rs2_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst state", 64'(dbg_state), 64'd0);
    check("rst md_done", 64'(md_done), 64'd0);
    check("rst md_result", 64'(md_result), 64'd0);
    check("rst stall", 64'(stall), 64'd0);

    // Decode sweep
    foreach (dec_tab[i]) begin
      alu_op = dec_tab[i].op;
      instruction = dec_tab[i].instr;
      #1;
      check({"dec ", dec_tab[i].name, " alufn"}, 64'(alufn), 64'(dec_tab[i].alufn));
      check({"dec ", dec_tab[i].name, " is_mext"}, 64'(is_mext), 64'(dec_tab[i].mext));
      @(negedge clk);
    end

    // M-op vectors
    foreach (md_tab[i])
      run_m(md_tab[i].name, md_tab[i].f3, md_tab[i].a, md_tab[i].b, md_tab[i].res, md_tab[i].cyc);

    // kill together with in_valid in IDLE: nothing is accepted
    @(negedge clk);
    alu_op = 2'b11; instruction = mk(7'b0000001, 3'b000, 7'b0110011);
    rs1_val = 32'd3; rs2_val = 32'd5; in_valid = 1'b1; kill = 1'b1;
    #1;
    check("kill_idle stall", 64'(stall), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle state", 64'(dbg_state), 64'd0);

    // kill at cycle 10 of a DIVU
    held = md_result;
    alu_op = 2'b11; instruction = mk(7'b0000001, 3'b101, 7'b0110011);
    rs1_val = 32'd1000; rs2_val = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill stall", 64'(stall), 64'd0);
    check("kill state", 64'(dbg_state), 64'd0);
    check("kill md_result", 64'(md_result), 64'(held));
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (md_done) seen_done = 1'b1;
      @(negedge clk);
    end
    check("kill no_done", 64'(seen_done), 64'd0);
    run_m("mulhu_after_kill", 3'b011, 32'h12345678, 32'h00010000, 32'h00001234, MUL_CYC);

    // rst mid-CALC
    @(negedge clk);
    alu_op = 2'b11; instruction = mk(7'b0000001, 3'b101, 7'b0110011);
    rs1_val = 32'd50; rs2_val = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid state", 64'(dbg_state), 64'd0);
    check("rst_mid md_done", 64'(md_done), 64'd0);
    check("rst_mid md_result", 64'(md_result), 64'd0);
    check("rst_mid stall", 64'(stall), 64'd0);
    run_m("remu_after_rst", 3'b111, 32'd50, 32'd3, 32'd2, DIV_CYC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
